// File: rtl/wb_commit_stage.sv
// Writeback stage: drives NLANE register-file write ports with intra-bundle
// conflict resolution and serialises retired lanes through an in-order commit FIFO.
module wb_commit_stage #(
  parameter int NLANE = 2,
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANE-1:0]        in_lane_valid,
  input  logic [NLANE-1:0]        in_wb_en,
  input  logic [5*NLANE-1:0]      in_wd,
  input  logic [XLEN*NLANE-1:0]   in_data,
  input  logic [XLEN*NLANE-1:0]   in_pc,
  input  logic [32*NLANE-1:0]     in_instr,
  output logic [NLANE-1:0]        rf_we,
  output logic [5*NLANE-1:0]      rf_wa,
  output logic [XLEN*NLANE-1:0]   rf_wdata,
  output logic                    commit_valid,
  input  logic                    commit_ready,
  output logic                    commit_is_wb,
  output logic [4:0]              commit_wd,
  output logic [XLEN-1:0]         commit_data,
  output logic [XLEN-1:0]         commit_pc,
  output logic [31:0]             commit_instr,
  output logic [$clog2(DEPTH):0]  commit_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            isWb;
    logic [4:0]      wd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } rec_t;

  rec_t           mem [DEPTH];
  rec_t           laneRec [NLANE];
  logic [PW-1:0]  pushOff [NLANE];
  logic [PW-1:0]  rdPtr, wrPtr;
  logic [CW-1:0]  count, countNext, pushCnt;
  logic [NLANE-1:0] qual, weNext;
  logic           accept, popDo;

  assign accept = in_valid && in_ready;
  assign popDo  = (count != '0) && commit_ready;

  always_comb begin
    pushCnt = '0;
    qual    = '0;
    weNext  = '0;
    for (int i = 0; i < NLANE; i++) begin
      pushOff[i] = pushCnt[PW-1:0];
      if (in_lane_valid[i]) pushCnt = pushCnt + CW'(1);
      qual[i] = in_lane_valid[i] && in_wb_en[i] && (in_wd[5*i +: 5] != 5'd0);
      laneRec[i] = '{isWb:  in_wb_en[i] && (in_wd[5*i +: 5] != 5'd0),
                     wd:    in_wd[5*i +: 5],
                     data:  in_data[XLEN*i +: XLEN],
                     pc:    in_pc[XLEN*i +: XLEN],
                     instr: in_instr[32*i +: 32]};
    end
    // An older lane loses its port write when a younger lane targets the same register.
    for (int i = 0; i < NLANE; i++) begin
      weNext[i] = qual[i];
      for (int j = i + 1; j < NLANE; j++) begin
        if (qual[j] && (in_wd[5*j +: 5] == in_wd[5*i +: 5])) weNext[i] = 1'b0;
      end
    end
  end

  assign countNext = count + (accept ? pushCnt : CW'(0)) - CW'(popDo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      rf_we    <= '0;
      rf_wa    <= '0;
      rf_wdata <= '0;
    end else begin
      count    <= countNext;
      rdPtr    <= rdPtr + PW'(popDo);
      wrPtr    <= wrPtr + (accept ? pushCnt[PW-1:0] : PW'(0));
      in_ready <= (DEPTH - int'(countNext)) >= NLANE;
      rf_we    <= accept ? weNext : '0;
      if (accept) begin
        rf_wa    <= in_wd;
        rf_wdata <= in_data;
      end
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NLANE; i++) begin
        if (in_lane_valid[i]) mem[wrPtr + pushOff[i]] <= laneRec[i];
      end
    end
  end

  rec_t head;
  assign head         = commit_valid ? mem[rdPtr] : '0;
  assign commit_valid = (count != '0);
  assign commit_is_wb = head.isWb;
  assign commit_wd    = head.wd;
  assign commit_data  = head.data;
  assign commit_pc    = head.pc;
  assign commit_instr = head.instr;
  assign commit_count = count;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_wb_commit_stage;
  localparam int NLANE = 2;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [NLANE-1:0] in_lane_valid, in_wb_en;
  logic [5*NLANE-1:0] in_wd;
  logic [XLEN*NLANE-1:0] in_data, in_pc;
  logic [32*NLANE-1:0] in_instr;
  logic [NLANE-1:0] rf_we;
  logic [5*NLANE-1:0] rf_wa;
  logic [XLEN*NLANE-1:0] rf_wdata;
  logic commit_valid, commit_ready, commit_is_wb;
  logic [4:0] commit_wd;
  logic [XLEN-1:0] commit_data, commit_pc;
  logic [31:0] commit_instr;
  logic [$clog2(DEPTH):0] commit_count;

  wb_commit_stage #(.NLANE(NLANE), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_wb_en(in_wb_en), .in_wd(in_wd),
    .in_data(in_data), .in_pc(in_pc), .in_instr(in_instr),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_is_wb(commit_is_wb), .commit_wd(commit_wd), .commit_data(commit_data),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_count(commit_count));

  always #5 clk = ~clk;

  typedef struct {
    logic        isWb;
    logic [4:0]  wd;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] instr;
  } rec_t;

  rec_t q[$];
  logic expReady;
  logic [NLANE-1:0] expRfWe;
  logic [4:0]  expWa [NLANE];
  logic [63:0] expWd [NLANE];
  int nChecks = 0;
  int nFails  = 0;

  task automatic idle_inputs();
    in_valid = 0; in_lane_valid = '0; in_wb_en = '0;
    in_wd = '0; in_data = '0; in_pc = '0; in_instr = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic we, input logic [4:0] wd,
                          input logic [63:0] d, input logic [63:0] pc, input logic [31:0] ins);
    in_lane_valid[i] = v; in_wb_en[i] = we; in_wd[5*i +: 5] = wd;
    in_data[64*i +: 64] = d; in_pc[64*i +: 64] = pc; in_instr[32*i +: 32] = ins;
  endtask

  // Reference model: the last qualifying lane per register owns the write port;
  // the FIFO is a queue of records in program order.
  task automatic step();
    logic acc;
    int winner [32];
    rec_t r;
    acc = in_valid && expReady;
    expRfWe = '0;
    for (int k = 0; k < 32; k++) winner[k] = -1;
    if (acc) begin
      for (int i = 0; i < NLANE; i++)
        if (in_lane_valid[i] && in_wb_en[i] && in_wd[5*i +: 5] != 0) winner[in_wd[5*i +: 5]] = i;
      for (int k = 1; k < 32; k++)
        if (winner[k] >= 0) begin
          expRfWe[winner[k]] = 1'b1;
          expWa[winner[k]] = 5'(k);
          expWd[winner[k]] = in_data[64*winner[k] +: 64];
        end
    end
    if (q.size() != 0 && commit_ready) void'(q.pop_front());
    if (acc)
      for (int i = 0; i < NLANE; i++)
        if (in_lane_valid[i]) begin
          r.isWb = in_wb_en[i] && in_wd[5*i +: 5] != 0;
          r.wd = in_wd[5*i +: 5]; r.data = in_data[64*i +: 64];
          r.pc = in_pc[64*i +: 64]; r.instr = in_instr[32*i +: 32];
          q.push_back(r);
        end
    expReady = (DEPTH - q.size()) >= NLANE;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    q.delete(); expReady = 0; expRfWe = '0;
  endtask

  task automatic test_reset();
    rst = 1; commit_ready = 0; idle_inputs(); model_reset();
    repeat (2) @(posedge clk); #1;
    nChecks++;
    if ({in_ready, commit_valid, commit_count, rf_we, rf_wa, rf_wdata} !== '0) begin
      nFails++; $display("FAIL reset_outputs: got rdy=%b cv=%b cnt=%0d we=%b", in_ready, commit_valid, commit_count, rf_we);
    end
    nChecks++;
    if ({commit_is_wb, commit_wd, commit_data, commit_pc, commit_instr} !== '0) begin
      nFails++; $display("FAIL reset_commit_fields: got pc=%h data=%h want 0", commit_pc, commit_data);
    end
    rst = 0;
    step();
    nChecks++;
    if (in_ready !== 1'b1 || commit_valid !== 1'b0 || commit_count !== 0) begin
      nFails++; $display("FAIL reset_release: got rdy=%b cv=%b cnt=%0d want 1 0 0", in_ready, commit_valid, commit_count);
    end
  endtask

  task automatic test_basic();
    idle_inputs(); commit_ready = 1; in_valid = 1;
    set_lane(0, 1, 1, 5, 64'h11, 64'h1000, 32'h00500293);
    set_lane(1, 1, 1, 6, 64'h22, 64'h1004, 32'h00600313);
    step();
    nChecks++;
    if (rf_we !== 2'b11 || rf_wa !== {5'd6, 5'd5} || rf_wdata !== {64'h22, 64'h11}) begin
      nFails++; $display("FAIL basic_rf: got we=%b wa=%h wd=%h want 11 %h", rf_we, rf_wa, rf_wdata, {5'd6, 5'd5});
    end
    nChecks++;
    if (commit_count !== 2 || commit_valid !== 1 || commit_pc !== 64'h1000 || commit_is_wb !== 1) begin
      nFails++; $display("FAIL basic_rec0: got cnt=%0d pc=%h want 2 1000", commit_count, commit_pc);
    end
    idle_inputs();
    step();
    nChecks++;
    if (rf_we !== 2'b00 || commit_count !== 1 || commit_pc !== 64'h1004 || commit_data !== 64'h22 || commit_wd !== 6) begin
      nFails++; $display("FAIL basic_rec1: got we=%b cnt=%0d pc=%h data=%h want 00 1 1004 22", rf_we, commit_count, commit_pc, commit_data);
    end
    step();
    nChecks++;
    if (commit_count !== 0 || commit_valid !== 0) begin
      nFails++; $display("FAIL basic_drain: got cnt=%0d want 0", commit_count);
    end
  endtask

  task automatic test_conflict();
    idle_inputs(); commit_ready = 1; in_valid = 1;
    set_lane(0, 1, 1, 7, 64'hAA, 64'h2000, 32'h1);
    set_lane(1, 1, 1, 7, 64'hBB, 64'h2004, 32'h2);
    step();
    idle_inputs();
    nChecks++;
    if (rf_we !== 2'b10 || rf_wa[9:5] !== 7 || rf_wdata[127:64] !== 64'hBB) begin
      nFails++; $display("FAIL conflict_rf: got we=%b wa1=%0d wd1=%h want 10 7 bb", rf_we, rf_wa[9:5], rf_wdata[127:64]);
    end
    nChecks++;
    if (commit_is_wb !== 1 || commit_data !== 64'hAA) begin
      nFails++; $display("FAIL conflict_rec0: got is_wb=%b data=%h want 1 aa", commit_is_wb, commit_data);
    end
    step();
    nChecks++;
    if (commit_is_wb !== 1 || commit_data !== 64'hBB || commit_count !== 1) begin
      nFails++; $display("FAIL conflict_rec1: got is_wb=%b data=%h want 1 bb", commit_is_wb, commit_data);
    end
    step();
  endtask

  task automatic test_x0();
    idle_inputs(); commit_ready = 1; in_valid = 1;
    set_lane(0, 1, 1, 0, 64'h33, 64'h3000, 32'h3);
    step();
    idle_inputs();
    nChecks++;
    if (rf_we !== 2'b00 || commit_is_wb !== 0 || commit_count !== 1 || commit_pc !== 64'h3000) begin
      nFails++; $display("FAIL x0_suppress: got we=%b is_wb=%b cnt=%0d want 00 0 1", rf_we, commit_is_wb, commit_count);
    end
    step();
  endtask

  task automatic test_full();
    idle_inputs(); commit_ready = 0; in_valid = 1;
    set_lane(0, 1, 1, 9, 64'h44, 64'h4000, 32'h4);
    set_lane(1, 1, 1, 10, 64'h55, 64'h4004, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      step();
      nChecks++;
      if (commit_count !== ((k < 4 ? k : 4) * 2) || in_ready !== (k < 4)) begin
        nFails++; $display("FAIL full_fill_%0d: got cnt=%0d rdy=%b want %0d %b", k, commit_count, in_ready, (k < 4 ? k : 4) * 2, k < 4);
      end
    end
    commit_ready = 1;  // in_valid stays high: no accept while count > DEPTH-NLANE
    step();
    nChecks++;
    if (commit_count !== 7 || in_ready !== 0) begin
      nFails++; $display("FAIL full_pop7: got cnt=%0d rdy=%b want 7 0", commit_count, in_ready);
    end
    step();
    nChecks++;
    if (commit_count !== 6 || in_ready !== 1) begin
      nFails++; $display("FAIL full_pop6: got cnt=%0d rdy=%b want 6 1", commit_count, in_ready);
    end
    idle_inputs();
    repeat (6) step();
    nChecks++;
    if (commit_count !== 0) begin
      nFails++; $display("FAIL full_drain: got cnt=%0d want 0", commit_count);
    end
  endtask

  task automatic test_mask();
    idle_inputs(); commit_ready = 0; in_valid = 1;
    set_lane(1, 1, 1, 12, 64'h66, 64'h5004, 32'h6);
    step();
    nChecks++;
    if (commit_count !== 1 || rf_we !== 2'b10 || commit_pc !== 64'h5004) begin
      nFails++; $display("FAIL mask_push: got cnt=%0d we=%b pc=%h want 1 10 5004", commit_count, rf_we, commit_pc);
    end
    commit_ready = 1;
    set_lane(1, 1, 1, 13, 64'h77, 64'h5008, 32'h7);
    step();
    nChecks++;
    if (commit_count !== 1 || commit_pc !== 64'h5008) begin
      nFails++; $display("FAIL mask_push_pop: got cnt=%0d pc=%h want 1 5008", commit_count, commit_pc);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    idle_inputs(); commit_ready = 0; in_valid = 1;
    set_lane(0, 1, 1, 1, 64'h1, 64'h6000, 32'h8);
    set_lane(1, 1, 1, 2, 64'h2, 64'h6004, 32'h9);
    step();
    set_lane(1, 0, 0, 0, 0, 0, 0);
    step();
    nChecks++;
    if (commit_count !== 3) begin
      nFails++; $display("FAIL mid_prefill: got cnt=%0d want 3", commit_count);
    end
    #2 rst = 1; #1;
    model_reset();
    nChecks++;
    if (commit_count !== 0 || commit_valid !== 0 || rf_we !== 0 || in_ready !== 0) begin
      nFails++; $display("FAIL mid_reset: got cnt=%0d cv=%b we=%b rdy=%b want 0", commit_count, commit_valid, rf_we, in_ready);
    end
    idle_inputs();
    @(posedge clk); #1 rst = 0;
    step();
    nChecks++;
    if (in_ready !== 1 || commit_count !== 0) begin
      nFails++; $display("FAIL mid_release: got rdy=%b cnt=%0d want 1 0", in_ready, commit_count);
    end
  endtask

  task automatic test_random();
    rec_t h;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      commit_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NLANE; i++)
        set_lane(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {32'h0, $urandom}, $urandom);
      step();
      h = '{isWb: 0, wd: 0, data: 0, pc: 0, instr: 0};
      if (q.size() != 0) h = q[0];
      nChecks++;
      if (commit_count !== q.size() || commit_valid !== (q.size() != 0) || in_ready !== expReady) begin
        nFails++; $display("FAIL rand_state_%0d: got cnt=%0d cv=%b rdy=%b want %0d %b", c, commit_count, commit_valid, in_ready, q.size(), expReady);
      end
      nChecks++;
      if ({commit_is_wb, commit_wd, commit_data, commit_pc, commit_instr} !== {h.isWb, h.wd, h.data, h.pc, h.instr}) begin
        nFails++; $display("FAIL rand_head_%0d: got pc=%h data=%h wd=%0d wb=%b want %h %h %0d %b", c, commit_pc, commit_data, commit_wd, commit_is_wb, h.pc, h.data, h.wd, h.isWb);
      end
      nChecks++;
      if (rf_we !== expRfWe) begin
        nFails++; $display("FAIL rand_rfwe_%0d: got %b want %b", c, rf_we, expRfWe);
      end
      for (int i = 0; i < NLANE; i++)
        if (expRfWe[i]) begin
          nChecks++;
          if (rf_wa[5*i +: 5] !== expWa[i] || rf_wdata[64*i +: 64] !== expWd[i]) begin
            nFails++; $display("FAIL rand_rfdata_%0d_%0d: got %0d %h want %0d %h", c, i, rf_wa[5*i +: 5], rf_wdata[64*i +: 64], expWa[i], expWd[i]);
          end
        end
    end
    idle_inputs(); commit_ready = 1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_x0();
    test_full();
    test_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
